// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: program counter, ROM address generation and a
// 2-entry prefetch queue feeding decode over a valid/ready handshake.
// Optional macro FETCH_BOUND_CHECK_EN: fetches at or beyond 4*ROM_WORDS stop
// the fetcher in a sticky FAULT state instead of aliasing through the ROM.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 32
) (
  input  logic        Clk,
  input  logic        Clrn,
  output logic [31:0] Addr,
  input  logic [31:0] Inst,
  output logic        Valid,
  output logic [31:0] InstOut,
  output logic [31:0] PcOut,
  input  logic        Ready,
  input  logic        Redirect,
  input  logic [31:0] Target,
  input  logic        Halt,
  output logic        Fault
);

  localparam logic [31:0] ROM_BYTES        = 32'(ROM_WORDS * 4);
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [1:0] ST_FAULT = 2'd2;
`endif

  logic [31:0] fetchPc_q, fetchPc_d;
  logic [31:0] headPc_q, headPc_d;
  logic [31:0] headInst_q, headInst_d;
  logic [31:0] tailPc_q, tailPc_d;
  logic [31:0] tailInst_q, tailInst_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  state_q, state_d;

  logic        pop;
  logic        canTake;
  logic        fetchSlot;
  logic        outOfRange;
  logic        push;
  logic [1:0]  remaining;
  logic        unusedTargetBits;

  assign unusedTargetBits = ^Target[1:0];

`ifdef FETCH_BOUND_CHECK_EN
  assign outOfRange = (fetchPc_q >= ROM_BYTES);
  assign Fault      = (state_q == ST_FAULT);
`else
  logic unusedRomBytes;
  assign unusedRomBytes = ^ROM_BYTES;
  assign outOfRange     = 1'b0;
  assign Fault          = 1'b0;
`endif

  assign Addr    = fetchPc_q;
  assign Valid   = (count_q != 2'd0);
  assign InstOut = headInst_q;
  assign PcOut   = headPc_q;

  // Handshake qualifiers: a fetch slot exists when running, not halted, not
  // redirecting and the queue has (or is freeing) a free entry.
  always_comb begin
    pop       = Valid && Ready;
    canTake   = (count_q != 2'd2) || pop;
    fetchSlot = (state_q == ST_RUN) && !Halt && canTake && !Redirect;
    push      = fetchSlot && !outOfRange;
    remaining = count_q - {1'b0, pop};
  end

  // Queue and PC update; a redirect flushes everything but leaves the head
  // registers holding their last value so the outputs never go unknown.
  always_comb begin
    fetchPc_d  = fetchPc_q;
    headPc_d   = headPc_q;
    headInst_d = headInst_q;
    tailPc_d   = tailPc_q;
    tailInst_d = tailInst_q;
    count_d    = count_q;
    if (Redirect) begin
      count_d   = 2'd0;
      fetchPc_d = {Target[31:2], 2'b00};
    end else begin
      if (pop && (count_q == 2'd2)) begin
        headPc_d   = tailPc_q;
        headInst_d = tailInst_q;
      end
      if (push) begin
        fetchPc_d = fetchPc_q + 32'd4;
        if (remaining == 2'd0) begin
          headPc_d   = fetchPc_q;
          headInst_d = Inst;
        end else begin
          tailPc_d   = fetchPc_q;
          tailInst_d = Inst;
        end
      end
      count_d = remaining + {1'b0, push};
    end
  end

  // Fetch state: halt parks the fetcher, a redirect never changes the parked
  // state, and an out-of-range fetch attempt latches FAULT until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (Halt) begin
          state_d = ST_HOLD;
        end else if (fetchSlot && outOfRange) begin
`ifdef FETCH_BOUND_CHECK_EN
          state_d = ST_FAULT;
`endif
        end
      end
      ST_HOLD: begin
        if (!Halt && !Redirect) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State registers; reset discards the queue immediately.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      fetchPc_q  <= RESET_PC_ALIGNED;
      headPc_q   <= 32'd0;
      headInst_q <= 32'd0;
      tailPc_q   <= 32'd0;
      tailInst_q <= 32'd0;
      count_q    <= 2'd0;
      state_q    <= ST_RUN;
    end else begin
      fetchPc_q  <= fetchPc_d;
      headPc_q   <= headPc_d;
      headInst_q <= headInst_d;
      tailPc_q   <= tailPc_d;
      tailInst_q <= tailInst_d;
      count_q    <= count_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Testbench for inst_fetch_ctrl: directed stimulus with a scoreboard of the
// instructions decode is expected to accept, checked by a separate monitor.
// Builds with or without FETCH_BOUND_CHECK_EN.
module tb_inst_fetch_ctrl;

  logic        Clk;
  logic        Clrn;
  logic [31:0] Addr;
  logic [31:0] Inst;
  logic        Valid;
  logic [31:0] InstOut;
  logic [31:0] PcOut;
  logic        Ready;
  logic        Redirect;
  logic [31:0] Target;
  logic        Halt;
  logic        Fault;

  logic [31:0] rom [0:31];
  logic [63:0] sbQ [$];
  int          assertCount = 0;
  int          failCount   = 0;
  logic        unusedAddrBits;

  inst_fetch_ctrl dut (
    .Clk(Clk), .Clrn(Clrn), .Addr(Addr), .Inst(Inst), .Valid(Valid),
    .InstOut(InstOut), .PcOut(PcOut), .Ready(Ready), .Redirect(Redirect),
    .Target(Target), .Halt(Halt), .Fault(Fault)
  );

  // Combinational ROM model indexed by the word address
  assign Inst           = rom[Addr[6:2]];
  assign unusedAddrBits = ^{Addr[31:7], Addr[1:0]};

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ROM contents: three known words then a recognisable filler pattern
  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA500_0000 | 32'(i);
    rom[0] = 32'h8C02_0001;
    rom[1] = 32'h8C03_0002;
    rom[2] = 32'h0043_0020;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic hlt, input logic redir, input logic [31:0] tgt);
    Ready    = rdy;
    Halt     = hlt;
    Redirect = redir;
    Target   = tgt;
  endtask

  task automatic expectWord(input logic [31:0] pc, input logic [31:0] inst);
    sbQ.push_back({pc, inst});
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    Clrn = 1'b1;
    #1;
    Clrn = 1'b0;
    #2;
    checkOutput("reset Valid", {31'd0, Valid}, 32'd0);
    checkOutput("reset InstOut", InstOut, 32'd0);
    checkOutput("reset PcOut", PcOut, 32'd0);
    checkOutput("reset Addr", Addr, 32'd0);
    checkOutput("reset Fault", {31'd0, Fault}, 32'd0);
    Clrn = 1'b1;
  endtask

  // Monitor: every accepted head must match the next scoreboard entry
  always @(negedge Clk) begin
    if (Clrn && Valid && Ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected accept PcOut", PcOut, 32'hDEAD_BEEF);
      end else begin
        logic [63:0] exp;
        exp = sbQ.pop_front();
        checkOutput("accept PcOut", PcOut, exp[63:32]);
        checkOutput("accept InstOut", InstOut, exp[31:0]);
      end
    end
  end

  initial begin
    Clrn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Streaming with Ready high: PCs 0,4,8 back-to-back
    applyReset();
    expectWord(32'h0, 32'h8C02_0001);
    expectWord(32'h4, 32'h8C03_0002);
    expectWord(32'h8, 32'h0043_0020);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("first fetch Valid", {31'd0, Valid}, 32'd1);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Backpressure: queue saturates at 2, Addr holds 8
    applyReset();
    repeat (5) tick();
    checkOutput("full Addr", Addr, 32'h8);
    checkOutput("full PcOut", PcOut, 32'h0);
    checkOutput("full InstOut", InstOut, 32'h8C02_0001);
    checkOutput("full Valid", {31'd0, Valid}, 32'd1);
    expectWord(32'h0, 32'h8C02_0001);
    expectWord(32'h4, 32'h8C03_0002);
    expectWord(32'h8, 32'h0043_0020);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect while PC 8 is accepted, target 0x13 aligns to 0x10
    applyReset();
    expectWord(32'h0, 32'h8C02_0001);
    expectWord(32'h4, 32'h8C03_0002);
    expectWord(32'h8, 32'h0043_0020);
    expectWord(32'h10, 32'hA500_0004);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    checkOutput("pre-redirect PcOut", PcOut, 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0013);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("post-redirect Valid", {31'd0, Valid}, 32'd0);
    checkOutput("post-redirect Addr", Addr, 32'h10);
    tick();
    checkOutput("redirect target Valid", {31'd0, Valid}, 32'd1);
    checkOutput("redirect target PcOut", PcOut, 32'h10);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Halt with a full queue: drain two, freeze Addr, then resume
    applyReset();
    repeat (2) tick();
    expectWord(32'h0, 32'h8C02_0001);
    expectWord(32'h4, 32'h8C03_0002);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) tick();
    checkOutput("halt drained Valid", {31'd0, Valid}, 32'd0);
    checkOutput("halt frozen Addr", Addr, 32'h8);
    repeat (2) tick();
    checkOutput("halt still frozen Addr", Addr, 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("resume first edge Valid", {31'd0, Valid}, 32'd0);
    expectWord(32'h8, 32'h0043_0020);
    tick();
    checkOutput("resume Valid", {31'd0, Valid}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect beyond the ROM
    applyReset();
`ifdef FETCH_BOUND_CHECK_EN
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h80);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("oob Addr", Addr, 32'h80);
    checkOutput("oob pre-fault Fault", {31'd0, Fault}, 32'd0);
    tick();
    checkOutput("oob Fault", {31'd0, Fault}, 32'd1);
    checkOutput("oob Valid", {31'd0, Valid}, 32'd0);
    checkOutput("oob held Addr", Addr, 32'h80);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("fault sticky Fault", {31'd0, Fault}, 32'd1);
    checkOutput("fault redirect Addr", Addr, 32'h0);
    tick();
    checkOutput("fault no fetch Valid", {31'd0, Valid}, 32'd0);
    checkOutput("fault still Fault", {31'd0, Fault}, 32'd1);
    Clrn = 1'b0;
    #1;
    checkOutput("fault cleared by reset", {31'd0, Fault}, 32'd0);
    Clrn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
`else
    expectWord(32'h80, 32'h8C02_0001);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h80);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("alias Addr", Addr, 32'h80);
    tick();
    checkOutput("alias Valid", {31'd0, Valid}, 32'd1);
    checkOutput("alias Fault", {31'd0, Fault}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
`endif

    // Asynchronous reset mid-stream with a full queue
    applyReset();
    repeat (3) tick();
    checkOutput("pre-async Valid", {31'd0, Valid}, 32'd1);
    #2;
    Clrn = 1'b0;
    #1;
    checkOutput("async Valid", {31'd0, Valid}, 32'd0);
    checkOutput("async InstOut", InstOut, 32'd0);
    checkOutput("async PcOut", PcOut, 32'd0);
    checkOutput("async Addr", Addr, 32'd0);
    #1;
    Clrn = 1'b1;
    tick();
    checkOutput("post-async first PcOut", PcOut, 32'h0);
    checkOutput("post-async first Valid", {31'd0, Valid}, 32'd1);

    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction fetch controller for the single-cycle/pipelined CPU. Owns the program counter, drives the word address of the 32-word combinational instruction ROM, and buffers fetched words in a 2-entry prefetch queue that feeds decode over a valid/ready handshake. Handles branch/jump redirects (queue flush), fetch hold, and optional out-of-range fetch faulting.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] ignored, treated as 0)
- ROM_WORDS, 32, ROM size in words; a power of two; in-range iff FetchPc < 4*ROM_WORDS

- Clk  in  1  rising-edge clock
- Clrn  in  1  asynchronous active-low reset
- Addr  out  32  ROM byte address; equals internal FetchPc, combinational
- Inst  in  32  ROM data for Addr, same cycle
- Valid  out  1  queue head holds an instruction
- InstOut  out  32  queue head instruction
- PcOut  out  32  byte address of InstOut
- Ready  in  1  decode accepts head this cycle
- Redirect  in  1  branch/jump taken; flush and refetch from Target
- Target  in  32  redirect byte address
- Halt  in  1  level; suppress new fetches while high
- Fault  out  1  sticky out-of-range fetch flag (tied 0 without FETCH_BOUND_CHECK_EN)

## Operation
- State: FetchPc (32), queue of 2 entries {pc, inst}, count 0..2, FSM {RUN, HOLD, FAULT}.
- Pop: Valid && Ready. Push: state RUN && (count<2 || pop) && !Redirect; pushes {FetchPc, Inst}, FetchPc += 4 (mod 2^32).
- Full (count==2, no pop): no push, FetchPc held; push+pop at full allowed, count stays 2.
- Empty: Valid=0; InstOut/PcOut hold last head value (don't-care to decode, but must not be X).
- Redirect (priority over everything except reset): queue flushed (count=0), FetchPc <= {Target[31:2],2'b00}; a same-cycle pop still completes (it is the branch itself); Inst on that cycle discarded. Redirect in HOLD keeps HOLD; in FAULT keeps FAULT.
- FSM: RUN->HOLD when Halt=1; HOLD->RUN when Halt=0; any->FAULT per Configuration. Queue continues to drain in HOLD and FAULT.
- Reset: FetchPc=RESET_PC, count=0, Valid=0, InstOut=0, PcOut=0, Fault=0, state RUN. Reset mid-operation discards queue contents immediately (asynchronous).

## Timing
- Addr combinational from FetchPc; Inst sampled at the same edge FetchPc advances.
- Fetch-to-Valid: 1 cycle (word pushed on edge N visible on Valid/InstOut after edge N).
- Redirect-to-Valid: 2 cycles (edge N: flush/load; edge N+1: push Target word; Valid high after N+1).
- Throughput: 1 instruction/cycle with Ready held high.
- Halt asserted at edge N: no push at edge N; queue drains at 1/cycle.
- First push occurs on first rising edge after Clrn deasserts.

## Configuration
- FETCH_BOUND_CHECK_EN defined: in RUN, if FetchPc >= 4*ROM_WORDS at a push opportunity, no push occurs, state -> FAULT, Fault=1 sticky until reset; only reset leaves FAULT. Redirect to out-of-range Target faults on the next push opportunity.
- Undefined: no check; addresses alias through ROM word indexing (Addr[6:2] for 32 words); Fault constant 0; FSM has no FAULT state.

## Test plan
- Reset, Ready=1, ROM words 0..2 = 8C020001, 8C030002, 00430020 -> Valid after 1st edge; (PcOut,InstOut) = (0,8C020001),(4,8C030002),(8,00430020) on consecutive cycles.
- Ready=0 for 5 cycles after reset -> count saturates at 2, Addr holds 8, head stays PC 0; Ready=1 -> PCs 0,4,8 delivered back-to-back, no gap.
- Redirect=1, Target=32'h0000_0013 while head PC 8 accepted -> PC 8 consumed, Valid=0 next cycle, then PcOut=0x10.
- Halt=1 with count=2 -> 2 more pops then Valid=0, Addr frozen; Halt=0 -> fetch resumes from frozen Addr.
- With FETCH_BOUND_CHECK_EN: Redirect to 0x80 -> Fault=1 one cycle later, Valid stays 0, Addr 0x80; Redirect to 0 does not clear; Clrn pulse clears Fault. Without macro: 0x80 fetches ROM word 0, Fault=0.
- Clrn asserted mid-stream with count=2 -> Valid=0, InstOut=0, PcOut=0, Addr=RESET_PC immediately, without waiting for Clk.
